// File: rtl/vector_dot_unit.sv
// rtl/vector_dot_unit.sv - sequential signed dot-product engine writing a saturated scalar back to vector_regs
//
// Reads two vector registers from vector_regs one after the other, multiply-
// accumulates their signed elements one element per cycle, then arithmetically
// shifts and saturates the sum to ELEM_W bits. The result is written into a
// single element of vector_regs. Command latency is 19 cycles from the start
// edge to the write commit.
//
// Optional build macro: VECTOR_DOT_RELU_EN
//   defined   - a negative saturated result is written as zero (ReLU).
//   undefined - the signed saturated result is written unchanged.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            command strobe, sampled only while idle
//   src_a, src_b     operand register indices
//   dst              destination {register[5:4], element[3:0]}
//   shift            arithmetic right shift applied before saturation
//   busy             high while a command is in flight
//   done             one-cycle pulse coincident with the result write
//   read_addr        vector_regs read port address (holds its last value)
//   read_data        vector_regs read port data (combinational on read_addr)
//   we, write_addr,
//   write_data       vector_regs element write port
module vector_dot_unit #(
  parameter int ELEM_W = 16,
  parameter int N_ELEM = 16,
  parameter int ACC_W  = 36
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               src_a,
  input  logic [1:0]               src_b,
  input  logic [5:0]               dst,
  input  logic [4:0]               shift,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               read_addr,
  input  logic [N_ELEM*ELEM_W-1:0] read_data,
  output logic                     we,
  output logic [5:0]               write_addr,
  output logic [ELEM_W-1:0]        write_data
);

  localparam int IDX_W  = $clog2(N_ELEM);
  localparam int PROD_W = 2 * ELEM_W;

  // Saturation bounds expressed at accumulator width so the compare is a
  // plain signed compare against the shifted sum.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-ELEM_W+1){1'b0}}, {(ELEM_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-ELEM_W+1){1'b1}}, {(ELEM_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_MAC,
    S_WRITE
  } state_t;

  state_t state, state_next;

  logic [1:0]                src_b_q;
  logic [5:0]                dst_q;
  logic [4:0]                shift_q;
  logic [N_ELEM*ELEM_W-1:0]  op_a;
  logic [N_ELEM*ELEM_W-1:0]  op_b;
  logic signed [ACC_W-1:0]   acc;
  logic [IDX_W-1:0]          idx;

  logic signed [ELEM_W-1:0]  elem_a;
  logic signed [ELEM_W-1:0]  elem_b;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   shifted;
  logic [ELEM_W-1:0]         sat_val;
  logic [ELEM_W-1:0]         result;
  logic                      last_idx;

  assign last_idx = (idx == IDX_W'(N_ELEM - 1));

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next state and control outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    we         = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = S_LOAD_A;
        end
      end
      S_LOAD_A: state_next = S_LOAD_B;
      S_LOAD_B: state_next = S_MAC;
      S_MAC: begin
        if (last_idx) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        we         = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Element select and multiply
  // ---------------------------------------------------------------------
  always_comb begin
    elem_a   = op_a[ELEM_W*int'(idx) +: ELEM_W];
    elem_b   = op_b[ELEM_W*int'(idx) +: ELEM_W];
    prod     = elem_a * elem_b;
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_b_q   <= '0;
      dst_q     <= '0;
      shift_q   <= '0;
      read_addr <= '0;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      idx       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // read_addr is registered so it already shows src_a during LOAD_A
            src_b_q   <= src_b;
            dst_q     <= dst;
            shift_q   <= shift;
            read_addr <= src_a;
          end
        end
        S_LOAD_A: begin
          op_a      <= read_data;
          read_addr <= src_b_q;
        end
        S_LOAD_B: begin
          op_b <= read_data;
          acc  <= '0;
          idx  <= '0;
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Shift, saturate and optional activation
  // ---------------------------------------------------------------------
  always_comb begin
    // The shift field can in principle exceed the accumulator width; in that
    // case only the sign survives.
    if (32'(shift_q) >= ACC_W) begin
      shifted = {ACC_W{acc[ACC_W-1]}};
    end else begin
      shifted = acc >>> shift_q;
    end

    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[ELEM_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[ELEM_W-1:0];
    end else begin
      sat_val = shifted[ELEM_W-1:0];
    end

`ifdef VECTOR_DOT_RELU_EN
    result = sat_val[ELEM_W-1] ? '0 : sat_val;
`else
    result = sat_val;
`endif
  end

  assign write_addr = dst_q;
  assign write_data = (state == S_WRITE) ? result : '0;

endmodule

// File: tb/tb_vector_dot_unit.sv
// tb/tb_vector_dot_unit.sv - directed self-checking bench for vector_dot_unit with a vector_regs model
module tb_vector_dot_unit;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   src_a;
  logic [1:0]   src_b;
  logic [5:0]   dst;
  logic [4:0]   shift;
  logic         busy;
  logic         done;
  logic [1:0]   read_addr;
  logic [255:0] read_data;
  logic         we;
  logic [5:0]   write_addr;
  logic [15:0]  write_data;

  logic [255:0] mem [4];
  logic         fill_en;
  logic [1:0]   fill_reg;
  logic [255:0] fill_val;

  int checks;
  int errors;

  vector_dot_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_a      (src_a),
    .src_b      (src_b),
    .dst        (dst),
    .shift      (shift),
    .busy       (busy),
    .done       (done),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .we         (we),
    .write_addr (write_addr),
    .write_data (write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign read_data = mem[read_addr];

  always @(posedge clk) begin
    if (fill_en) mem[fill_reg] <= fill_val;
    if (we) mem[write_addr[5:4]][16*int'(write_addr[3:0]) +: 16] <= write_data;
  end

  task automatic fill_reg_all(input logic [1:0] r, input logic [15:0] v);
    @(negedge clk);
    fill_en  = 1'b1;
    fill_reg = r;
    fill_val = {16{v}};
    @(negedge clk);
    fill_en  = 1'b0;
  endtask

  task automatic fill_reg_vec(input logic [1:0] r, input logic [255:0] v);
    @(negedge clk);
    fill_en  = 1'b1;
    fill_reg = r;
    fill_val = v;
    @(negedge clk);
    fill_en  = 1'b0;
  endtask

  // Issues one command and watches it until busy drops (bounded).
  task automatic run_cmd(input logic [1:0] sa, input logic [1:0] sb,
                         input logic [5:0] d, input logic [4:0] sh,
                         output int busy_cyc, output int we_cnt,
                         output logic [5:0] waddr, output logic [15:0] wdata,
                         output bit done_ok, output bit tmo);
    busy_cyc = 0;
    we_cnt   = 0;
    waddr    = '0;
    wdata    = '0;
    done_ok  = 1'b0;
    tmo      = 1'b1;
    @(negedge clk);
    start = 1'b1; src_a = sa; src_b = sb; dst = d; shift = sh;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        tmo = 1'b0;
        break;
      end
      busy_cyc++;
      if (we) begin
        we_cnt++;
        waddr   = write_addr;
        wdata   = write_data;
        done_ok = done;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, we} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/we=%b expected 000", {busy, done, we});
    end
    checks++;
    if ({read_addr, write_addr, write_data} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: ra=%h wa=%h wd=%h expected all 0", read_addr, write_addr, write_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int bc, wc; logic [5:0] wa; logic [15:0] wd; bit dn, to;
    fill_reg_all(2'd0, 16'h0001);
    fill_reg_all(2'd1, 16'h0002);
    fill_reg_all(2'd2, 16'h0000);
    run_cmd(2'd0, 2'd1, 6'h20, 5'd0, bc, wc, wa, wd, dn, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout: busy still high after 40 cycles"); end
    checks++;
    if (bc != 19) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 19", bc); end
    checks++;
    if (wc != 1 || !dn) begin errors++; $display("FAIL basic_we_done: we_count=%0d done=%0d expected 1,1", wc, dn); end
    checks++;
    if (wa !== 6'h20) begin errors++; $display("FAIL basic_waddr: got %h expected 20", wa); end
    checks++;
    if (wd !== 16'h0020) begin errors++; $display("FAIL basic_wdata: got %h expected 0020", wd); end
    checks++;
    if (mem[2][15:0] !== 16'h0020) begin errors++; $display("FAIL basic_mem: reg2[0]=%h expected 0020", mem[2][15:0]); end
  endtask

  task automatic test_pos_sat;
    int bc, wc; logic [5:0] wa; logic [15:0] wd; bit dn, to;
    fill_reg_all(2'd0, 16'h7FFF);
    fill_reg_all(2'd1, 16'h7FFF);
    run_cmd(2'd0, 2'd1, 6'h21, 5'd0, bc, wc, wa, wd, dn, to);
    checks++;
    if (to || wc != 1 || wd !== 16'h7FFF) begin
      errors++;
      $display("FAIL pos_sat: wdata=%h we_count=%0d timeout=%0d expected 7fff,1,0", wd, wc, to);
    end
  endtask

  task automatic test_negative;
    int bc, wc; logic [5:0] wa; logic [15:0] wd; bit dn, to;
    logic [15:0] exp_neg, exp_sign, exp_nsat;
`ifdef VECTOR_DOT_RELU_EN
    exp_neg = 16'h0000; exp_sign = 16'h0000; exp_nsat = 16'h0000;
`else
    exp_neg = 16'hFFD0; exp_sign = 16'hFFFF; exp_nsat = 16'h8000;
`endif
    fill_reg_all(2'd0, 16'hFFFF);
    fill_reg_all(2'd1, 16'h0003);
    run_cmd(2'd0, 2'd1, 6'h22, 5'd0, bc, wc, wa, wd, dn, to);
    checks++;
    if (to || wd !== exp_neg) begin errors++; $display("FAIL neg_sum: wdata=%h expected %h", wd, exp_neg); end
    // -48 shifted right by 31 keeps only the sign
    run_cmd(2'd0, 2'd1, 6'h23, 5'd31, bc, wc, wa, wd, dn, to);
    checks++;
    if (to || wd !== exp_sign) begin errors++; $display("FAIL neg_big_shift: wdata=%h expected %h", wd, exp_sign); end
    fill_reg_all(2'd0, 16'h8000);
    fill_reg_all(2'd1, 16'h7FFF);
    run_cmd(2'd0, 2'd1, 6'h24, 5'd0, bc, wc, wa, wd, dn, to);
    checks++;
    if (to || wd !== exp_nsat) begin errors++; $display("FAIL neg_sat: wdata=%h expected %h", wd, exp_nsat); end
  endtask

  // a[i] = i-8, b[i] = i: sum i*(i-8) = 1240 - 960 = 280; >>>2 = 70
  task automatic test_mixed;
    int bc, wc; logic [5:0] wa; logic [15:0] wd; bit dn, to;
    logic [255:0] va, vb;
    for (int i = 0; i < 16; i++) begin
      va[16*i +: 16] = 16'(i - 8);
      vb[16*i +: 16] = 16'(i);
    end
    fill_reg_vec(2'd0, va);
    fill_reg_vec(2'd1, vb);
    run_cmd(2'd0, 2'd1, 6'h25, 5'd2, bc, wc, wa, wd, dn, to);
    checks++;
    if (to || wd !== 16'h0046) begin errors++; $display("FAIL mixed_elems: wdata=%h expected 0046", wd); end
    checks++;
    if (mem[2][16*5 +: 16] !== 16'h0046) begin errors++; $display("FAIL mixed_mem: reg2[5]=%h expected 0046", mem[2][16*5 +: 16]); end
  endtask

  task automatic test_square_in_place;
    int bc, wc; logic [5:0] wa; logic [15:0] wd; bit dn, to;
    int bad;
    fill_reg_all(2'd3, 16'h0100);
    run_cmd(2'd3, 2'd3, 6'h3F, 5'd8, bc, wc, wa, wd, dn, to);
    checks++;
    if (to || wd !== 16'h1000 || wa !== 6'h3F) begin
      errors++;
      $display("FAIL square_wdata: wdata=%h waddr=%h expected 1000,3f", wd, wa);
    end
    @(negedge clk);
    checks++;
    if (mem[3][255:240] !== 16'h1000) begin errors++; $display("FAIL square_mem15: reg3[15]=%h expected 1000", mem[3][255:240]); end
    bad = 0;
    for (int i = 0; i < 15; i++) if (mem[3][16*i +: 16] !== 16'h0100) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL square_others: %0d of reg3[0..14] differ, expected 0100", bad); end
  endtask

  task automatic test_start_ignored;
    int wc; logic [5:0] wa; logic [15:0] wd;
    fill_reg_all(2'd0, 16'h0001);
    fill_reg_all(2'd1, 16'h0002);
    fill_reg_all(2'd2, 16'h0000);
    fill_reg_all(2'd3, 16'h0100);
    wc = 0; wa = '0; wd = '0;
    @(negedge clk);
    start = 1'b1; src_a = 2'd0; src_b = 2'd1; dst = 6'h21; shift = 5'd0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      // second command with different operands lands in the MAC phase
      if (i == 0) start = 1'b0;
      if (i == 6) begin start = 1'b1; src_a = 2'd3; src_b = 2'd3; dst = 6'h22; shift = 5'd8; end
      if (i == 8) start = 1'b0;
      if (we) begin wc++; wa = write_addr; wd = write_data; end
    end
    checks++;
    if (wc != 1) begin errors++; $display("FAIL ignore_count: we_count=%0d expected 1", wc); end
    checks++;
    if (wa !== 6'h21 || wd !== 16'h0020) begin errors++; $display("FAIL ignore_result: waddr=%h wdata=%h expected 21,0020", wa, wd); end
    checks++;
    if (mem[2][16*2 +: 16] !== 16'h0000) begin errors++; $display("FAIL ignore_mem: reg2[2]=%h expected 0000", mem[2][16*2 +: 16]); end
  endtask

  task automatic test_reset_abort;
    int bc, wc; logic [5:0] wa; logic [15:0] wd; bit dn, to;
    fill_reg_all(2'd2, 16'h5555);
    @(negedge clk);
    start = 1'b1; src_a = 2'd0; src_b = 2'd1; dst = 6'h25; shift = 5'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    // now in MAC with idx == 7
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, we} !== 3'b000) begin errors++; $display("FAIL abort_outputs: busy/done/we=%b expected 000", {busy, done, we}); end
    @(negedge clk);
    rst_n = 1'b1;
    wc = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (we) wc++;
    end
    checks++;
    if (wc != 0) begin errors++; $display("FAIL abort_no_write: we_count=%0d expected 0", wc); end
    checks++;
    if (mem[2][16*5 +: 16] !== 16'h5555) begin errors++; $display("FAIL abort_mem: reg2[5]=%h expected 5555", mem[2][16*5 +: 16]); end
    run_cmd(2'd0, 2'd1, 6'h25, 5'd0, bc, wc, wa, wd, dn, to);
    @(negedge clk);
    checks++;
    if (to || bc != 19 || wd !== 16'h0020 || mem[2][16*5 +: 16] !== 16'h0020) begin
      errors++;
      $display("FAIL abort_recover: busy_cycles=%0d wdata=%h mem=%h expected 19,0020,0020", bc, wd, mem[2][16*5 +: 16]);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    src_a    = '0;
    src_b    = '0;
    dst      = '0;
    shift    = '0;
    fill_en  = 1'b0;
    fill_reg = '0;
    fill_val = '0;
    test_reset();
    test_basic();
    test_pos_sat();
    test_negative();
    test_mixed();
    test_square_in_place();
    test_start_ignored();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_dot_unit.md
Name: vector_dot_unit

Overview:
- Sequential dot-product engine directly downstream of vector_regs, which holds 4 registers × 16 signed 16-bit elements.
- Reads two source vector registers through the vector_regs read port and multiply-accumulates them element by element.
- Writes the scaled, saturated 16-bit scalar back into one element of vector_regs through its element write port (we/write_addr/write_data).
- Lets the NPU compute one neuron output per command without host involvement.

Parameters:
- ELEM_W, 16, element width in bits; must match vector_regs WIDTH.
- N_ELEM, 16, elements per vector register; 256 = N_ELEM*ELEM_W.
- ACC_W, 36, accumulator width: 2*ELEM_W + log2(N_ELEM). Must be ≥ that value so the accumulator never wraps.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- src_a  in  2  first operand register index.
- src_b  in  2  second operand register index.
- dst  in  6  destination: [5:4] register, [3:0] element.
- shift  in  5  arithmetic right shift applied to the sum before saturation.
- busy  out  1  high while a command is in flight.
- done  out  1  one-cycle pulse, coincident with the result write.
- read_addr  out  2  to vector_regs read_addr.
- read_data  in  256  from vector_regs read_data; combinational w.r.t. read_addr.
- we  out  1  to vector_regs we.
- write_addr  out  6  to vector_regs write_addr.
- write_data  out  16  to vector_regs write_data.

Behaviour:
- Reset values: all outputs 0. Asynchronous assert; synchronous-release-safe (registers only).
- State machine: IDLE → LOAD_A → LOAD_B → MAC → WRITE → IDLE.
- IDLE: busy=0. On start=1 at an edge, capture src_a, src_b, dst and shift; go to LOAD_A. Edge E0 is the edge where start is sampled.
- LOAD_A (1 cycle): read_addr=src_a. Latch read_data into op_a at E1.
- LOAD_B (1 cycle): read_addr=src_b. Latch op_b and clear acc and idx at E2.
- MAC (N_ELEM cycles, edges E3..E18): acc += sext(a[idx]) × sext(b[idx]), signed. Element i is bits [16i+15:16i]. idx counts 0..15; leave on idx==15.
- WRITE (1 cycle, committed at E19): we=1, done=1, write_addr=dst.
  - write_data = sat16(acc >>> shift); saturation range [-32768, 32767].
  - Return to IDLE at E19.
- busy=1 in all states except IDLE. Total latency from the start edge to the write commit is 19 cycles.
- start is ignored while busy (no queueing). Operands captured at E0 are not affected by later input changes.
- src_a==src_b is legal (square sum).
- dst may lie inside src_a or src_b: both operands are latched before any write, so there is no hazard.
- read_addr holds its last value outside the LOAD states. we and done are 0 outside WRITE.
- shift ≥ ACC_W yields 0 or -1 according to the sign of acc.
- rst_n low mid-operation: immediate abort to IDLE; no write issued; busy and done go to 0.
- While busy, this block owns the vector_regs element write port; the system must not assert full_we or any other writer during that time.

Optional Feature:
- Macro: VECTOR_DOT_RELU_EN.
- Defined: after shift and saturation, a negative result is written as 0x0000 (ReLU activation). Positive results are unchanged.
- Undefined: the signed saturated result is written as-is. No ReLU logic is present.

Test Plan:
- Reg0 all 0x0001, reg1 all 0x0002; start src_a=0, src_b=1, dst=6'h20, shift=0.
  - Expect busy for 19 cycles, then one cycle with we=1, done=1, write_addr=6'h20, write_data=0x0020. Reg2 element 0 reads 0x0020.
- Reg0 and reg1 all 0x7FFF, shift=0 → write_data=0x7FFF (positive saturation).
- Reg0 all 0xFFFF (-1), reg1 all 0x0003, shift=0:
  - write_data=0xFFD0 (-48).
  - With VECTOR_DOT_RELU_EN defined: write_data=0x0000.
- Reg3 all 0x0100, src_a=src_b=3, dst=6'h3F, shift=8 → write_data=0x1000.
  - Reg3 element 15 then reads 0x1000; the other reg3 elements remain 0x0100.
- Assert start again during MAC (different operands) → ignored. Exactly one write, with the original result.
- Drop rst_n for 1 cycle at MAC idx=7 → busy=0 immediately, no we pulse, destination element unchanged. A subsequent start completes normally.
